seq_alu: RTL and testbench

//  Arithmetic stage feeding the accumulator: takes AC value (a) and a memory/register operand (b), computes

---
 rtl/seq_alu_pkg.sv | 25 ++
 rtl/seq_alu_if.sv | 26 ++
 rtl/seq_alu_shift_add_mult.sv | 45 ++++
 rtl/seq_alu.sv | 122 ++++++++++++
 tb/tb_seq_alu.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU and the control unit that drives it:
// opcode and FSM state encodings plus default datapath sizing.
package seq_alu_pkg;

    localparam int WORD_W_DEF = 24;
    localparam int CNT_W_DEF  = 5;

    typedef enum logic [2:0] {
        OP_PASS_B = 3'd0,
        OP_ADD    = 3'd1,
        OP_SUB    = 3'd2,
        OP_MUL    = 3'd3,
        OP_AND    = 3'd4,
        OP_OR     = 3'd5,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the control unit (master) and the ALU (slave).
interface seq_alu_if
    import seq_alu_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
);
    logic              start;
    op_e               op;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] result;
    logic              zero;
    logic              ovf;

    modport master (
        output start, op, a, b,
        input  busy, done, result, zero, ovf
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, zero, ovf
    );
endinterface

// File: rtl/seq_alu_shift_add_mult.sv
// Iterative shift-add multiplier: one partial product per step, full 2*WORD_W
// accumulator so the caller can detect products that overflow one word.
module seq_alu_shift_add_mult #(
    parameter int WORD_W = 24,
    parameter int CNT_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic [WORD_W-1:0]   a,
    input  logic [WORD_W-1:0]   b,
    output logic                last,
    output logic [2*WORD_W-1:0] product
);
    logic [2*WORD_W-1:0] mcand;
    logic [WORD_W-1:0]   mplier;
    logic [2*WORD_W-1:0] acc;
    logic [CNT_W-1:0]    cnt;

    // product already includes this step's partial product, so on the last
    // step it is the final value the top registers into result.
    assign product = mplier[0] ? (acc + mcand) : acc;
    assign last    = (cnt == CNT_W'(WORD_W - 1));

    // Operand load on acceptance, then one shift-add iteration per step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{WORD_W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU feeding the accumulator: single-cycle PASS/ADD/SUB/AND/OR and a
// fixed-latency shift-add MUL, with registered result/flags and a one-cycle done.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    seq_alu_if.slave   bus
);
    state_e              state;
    state_e              state_nxt;
    logic                mul_load;
    logic                mul_step;
    logic                mul_last;
    logic [2*WORD_W-1:0] mul_product;
    logic                out_load;
    logic [WORD_W-1:0]   res_nxt;
    logic                ovf_nxt;
    logic [WORD_W:0]     single_res;
    logic [WORD_W-1:0]   result_q;
    logic                zero_q;
    logic                ovf_q;

    // Returns {ovf, result}; bit WORD_W of the widened sum/difference is the
    // ADD carry-out or the SUB borrow. Reserved opcodes pass A through.
    function automatic logic [WORD_W:0] alu_single(input op_e op,
                                                   input logic [WORD_W-1:0] a,
                                                   input logic [WORD_W-1:0] b);
        logic [WORD_W:0] r;
        case (op)
            OP_PASS_B: r = {1'b0, b};
            OP_ADD:    r = {1'b0, a} + {1'b0, b};
            OP_SUB:    r = {1'b0, a} - {1'b0, b};
            OP_AND:    r = {1'b0, a & b};
            OP_OR:     r = {1'b0, a | b};
            default:   r = {1'b0, a};
        endcase
        return r;
    endfunction

    function automatic logic is_zero(input logic [WORD_W-1:0] v);
        return (v == '0);
    endfunction

    assign single_res = alu_single(bus.op, bus.a, bus.b);

    seq_alu_shift_add_mult #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .step    (mul_step),
        .a       (bus.a),
        .b       (bus.b),
        .last    (mul_last),
        .product (mul_product)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next state, multiplier control and the value to register on entry to DONE.
    always_comb begin
        state_nxt = state;
        mul_load  = 1'b0;
        mul_step  = 1'b0;
        out_load  = 1'b0;
        res_nxt   = single_res[WORD_W-1:0];
        ovf_nxt   = single_res[WORD_W];
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MUL) begin
                        mul_load  = 1'b1;
                        state_nxt = ST_MUL_RUN;
                    end else begin
                        out_load  = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_MUL_RUN: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    out_load  = 1'b1;
                    res_nxt   = mul_product[WORD_W-1:0];
                    ovf_nxt   = |mul_product[2*WORD_W-1:WORD_W];
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output registers change only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (out_load) begin
            result_q <= res_nxt;
            zero_q   <= is_zero(res_nxt);
            ovf_q    <= ovf_nxt;
        end
    end

    assign bus.busy   = (state != ST_IDLE);
    assign bus.done   = (state == ST_DONE);
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases plus random operations
// checked against an arithmetic reference model.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 24;
    localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

    typedef struct {
        logic [W-1:0] result;
        logic         zero;
        logic         ovf;
        int           lat;
        int           t0;
        int           op;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.WORD_W(W)) bus ();

    seq_alu #(.WORD_W(W), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t         sb[$];
    exp_t         mon_e;
    int           checks   = 0;
    int           errors   = 0;
    int           cyc      = 0;
    int           n_issued = 0;
    int           n_done   = 0;
    logic [W-1:0] held     = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural rules.
    function automatic exp_t model(int op, longint unsigned a, longint unsigned b);
        exp_t e;
        longint unsigned r;
        bit o;
        o = 1'b0;
        e.lat = 1;
        case (op)
            0: r = b;
            1: begin r = a + b; o = (r > MASK); end
            2: begin r = (a - b) & MASK; o = (a < b); end
            3: begin r = a * b; o = ((r >> W) != 0); e.lat = W + 1; end
            4: r = a & b;
            5: r = a | b;
            default: r = a;
        endcase
        e.result = r[W-1:0];
        e.zero   = ((r & MASK) == 0);
        e.ovf    = o;
        e.op     = op;
        e.t0     = 0;
        return e;
    endfunction

    // Monitor: compares every done against the oldest pending expectation,
    // and checks that result holds between dones.
    always @(negedge clk) begin
        if (!rst) begin
            held = '0;
        end else if (bus.done) begin
            n_done++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 result=0x%0h expected no pending op", bus.result);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("result op%0d", mon_e.op), 64'(bus.result), 64'(mon_e.result));
                check($sformatf("zero op%0d", mon_e.op), 64'(bus.zero), 64'(mon_e.zero));
                check($sformatf("ovf op%0d", mon_e.op), 64'(bus.ovf), 64'(mon_e.ovf));
                check($sformatf("latency op%0d", mon_e.op), 64'(cyc - mon_e.t0), 64'(mon_e.lat));
                check("busy_in_done", 64'(bus.busy), 64'd1);
                held = bus.result;
            end
        end else begin
            check("result_hold", 64'(bus.result), 64'(held));
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 within 200 cycles");
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Waits for idle, presents one request for a single edge, then scrambles
    // the operand lines so late changes would corrupt a non-latched result.
    task automatic issue(int op, logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        logic [2:0] op3;
        wait_idle();
        op3       = op[2:0];
        bus.start = 1'b1;
        bus.op    = op_e'(op3);
        bus.a     = a;
        bus.b     = b;
        e         = model(op, 64'(a), 64'(b));
        e.t0      = cyc;
        sb.push_back(e);
        n_issued++;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        op3       = 3'($urandom_range(0, 7));
        bus.op    = op_e'(op3);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return W'(MASK);
            2:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.op    = OP_PASS_B;
        bus.a     = '0;
        bus.b     = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_zero", 64'(bus.zero), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        #2 rst = 1'b1;

        // ADD 5+7, busy high for exactly one cycle
        issue(1, 24'd5, 24'd7);
        check("add_busy_done_cycle", 64'(bus.busy), 64'd1);
        @(negedge clk);
        check("add_busy_after", 64'(bus.busy), 64'd0);
        wait_drain();

        // Carry, borrow and the MUL corners
        issue(1, 24'hFFFFFF, 24'd1);
        issue(2, 24'd3, 24'd5);
        issue(3, 24'd1000, 24'd3000);
        issue(3, 24'h1000, 24'h1000);
        issue(6, 24'h123456, 24'h654321);
        issue(0, 24'h123456, 24'hABCDEF);
        wait_drain();

        // Requests during MUL_RUN and during DONE are dropped
        issue(3, 24'd77, 24'd91);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 24'd1;
        bus.b     = 24'd2;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drop_saw_done", 64'(bus.done), 64'd1);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        @(negedge clk);
        bus.start = 1'b0;
        check("drop_busy_after_done", 64'(bus.busy), 64'd0);
        repeat (5) @(negedge clk);
        check("drop_pending", 64'(sb.size()), 64'd0);
        check("drop_done_count", 64'(n_done), 64'(n_issued));

        // Reset in the middle of a multiply aborts it with no done
        issue(3, 24'hABCDE, 24'h12345);
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        sb.delete();
        n_issued--;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_busy_after", 64'(bus.busy), 64'd0);
        check("abort_done_count", 64'(n_done), 64'(n_issued));

        // Back-to-back single-cycle ops
        issue(1, 24'd100, 24'd23);
        issue(4, 24'hF0F0F0, 24'hFF00FF);
        issue(5, 24'hF0F0F0, 24'h0F0F0F);
        repeat (6) @(negedge clk);
        wait_drain();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            issue($urandom_range(0, 7), pick_operand(), pick_operand());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        wait_drain();
        wait_idle();
        check("final_done_count", 64'(n_done), 64'(n_issued));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
